// File: rtl/id_pipe_stage.sv
// ARM decode stage: field extraction, condition check, register file and a stallable ID/EXE bundle.
// Optional macro ID_WB_BYPASS_EN forwards a same-cycle write-back into the operand reads.
module id_pipe_stage #(
    parameter int DATA_W = 32,
    parameter int NREG   = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [31:0]       i_instr_in,
    input  logic              i_instr_valid,
    output logic              o_id_ready,
    input  logic              i_exe_ready,
    input  logic              i_flush,
    input  logic              i_hazard,
    input  logic [3:0]        i_sr,
    input  logic [8:0]        i_ctrl_in,
    input  logic              i_wb_we,
    input  logic [3:0]        i_wb_dest,
    input  logic [DATA_W-1:0] i_wb_data,
    output logic [3:0]        o_src1,
    output logic [3:0]        o_src2,
    output logic              o_two_src,
    output logic              o_out_valid,
    output logic [3:0]        o_exe_cmd,
    output logic              o_wb_en,
    output logic              o_mem_r_en,
    output logic              o_mem_w_en,
    output logic              o_b,
    output logic              o_s,
    output logic [DATA_W-1:0] o_val_rn,
    output logic [DATA_W-1:0] o_val_rm,
    output logic              o_imm,
    output logic [11:0]       o_shift_operand,
    output logic [23:0]       o_signed_imm_24,
    output logic [3:0]        o_dest
);
    localparam logic [4:0] NREG_L = 5'(NREG);

    logic [DATA_W-1:0] w_rf [16];
    logic [3:0]        w_cond;
    logic [3:0]        w_rn;
    logic [3:0]        w_rd;
    logic [3:0]        w_rm_sel;
    logic              w_n;
    logic              w_z;
    logic              w_c;
    logic              w_v;
    logic              w_cond_pass;
    logic              w_load;
    logic [DATA_W-1:0] w_val_rn;
    logic [DATA_W-1:0] w_val_rm;
    logic              w_unused;

    logic              r_out_valid;
    logic [8:0]        r_ctrl;
    logic [DATA_W-1:0] r_val_rn;
    logic [DATA_W-1:0] r_val_rm;
    logic              r_imm;
    logic [11:0]       r_shift_operand;
    logic [23:0]       r_signed_imm_24;
    logic [3:0]        r_dest;

    assign w_cond   = i_instr_in[31:28];
    assign w_rn     = i_instr_in[19:16];
    assign w_rd     = i_instr_in[15:12];
    assign w_rm_sel = i_ctrl_in[2] ? w_rd : i_instr_in[3:0];
    assign w_unused = ^{i_instr_in[27:26], i_instr_in[24]};

    assign {w_n, w_z, w_c, w_v} = i_sr;

    // Unimplemented slots are tied to zero, so out-of-range reads return 0 and writes vanish.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_rf
            if (gi < NREG) begin : g_impl
                logic [DATA_W-1:0] r_q;
                always_ff @(posedge i_clk or negedge i_rst_n) begin
                    if (!i_rst_n) begin
                        r_q <= '0;
                    end else if (i_wb_we && (i_wb_dest == 4'(gi))) begin
                        r_q <= i_wb_data;
                    end
                end
                assign w_rf[gi] = r_q;
            end else begin : g_none
                assign w_rf[gi] = '0;
            end
        end
    endgenerate

    always_comb begin
        w_val_rn = w_rf[w_rn];
        w_val_rm = w_rf[w_rm_sel];
`ifdef ID_WB_BYPASS_EN
        if (i_wb_we && (i_wb_dest == w_rn) && ({1'b0, w_rn} < NREG_L)) begin
            w_val_rn = i_wb_data;
        end
        if (i_wb_we && (i_wb_dest == w_rm_sel) && ({1'b0, w_rm_sel} < NREG_L)) begin
            w_val_rm = i_wb_data;
        end
`endif
    end

    always_comb begin
        case (w_cond)
            4'h0:    w_cond_pass = w_z;
            4'h1:    w_cond_pass = ~w_z;
            4'h2:    w_cond_pass = w_c;
            4'h3:    w_cond_pass = ~w_c;
            4'h4:    w_cond_pass = w_n;
            4'h5:    w_cond_pass = ~w_n;
            4'h6:    w_cond_pass = w_v;
            4'h7:    w_cond_pass = ~w_v;
            4'h8:    w_cond_pass = w_c & ~w_z;
            4'h9:    w_cond_pass = ~w_c | w_z;
            4'hA:    w_cond_pass = (w_n == w_v);
            4'hB:    w_cond_pass = (w_n != w_v);
            4'hC:    w_cond_pass = ~w_z & (w_n == w_v);
            4'hD:    w_cond_pass = w_z | (w_n != w_v);
            4'hE:    w_cond_pass = 1'b1;
            default: w_cond_pass = 1'b0;
        endcase
    end

    assign w_load     = i_exe_ready | ~r_out_valid;
    assign o_id_ready = w_load & ~i_hazard;
    assign o_src1     = w_rn;
    assign o_src2     = w_rm_sel;
    assign o_two_src  = ~i_instr_in[25] | i_ctrl_in[2];

    // Bubbles and flushes clear the control bits so a stale bundle can never act in EXE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid     <= 1'b0;
            r_ctrl          <= '0;
            r_val_rn        <= '0;
            r_val_rm        <= '0;
            r_imm           <= 1'b0;
            r_shift_operand <= '0;
            r_signed_imm_24 <= '0;
            r_dest          <= '0;
        end else if (i_flush) begin
            r_out_valid <= 1'b0;
            r_ctrl      <= '0;
        end else if (w_load) begin
            if (i_hazard || !i_instr_valid) begin
                r_out_valid <= 1'b0;
                r_ctrl      <= '0;
            end else begin
                r_out_valid     <= 1'b1;
                r_ctrl          <= w_cond_pass ? i_ctrl_in : 9'd0;
                r_val_rn        <= w_val_rn;
                r_val_rm        <= w_val_rm;
                r_imm           <= i_instr_in[25];
                r_shift_operand <= i_instr_in[11:0];
                r_signed_imm_24 <= i_instr_in[23:0];
                r_dest          <= w_rd;
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign {o_exe_cmd, o_wb_en, o_mem_r_en, o_mem_w_en, o_b, o_s} = r_ctrl;
    assign o_val_rn        = r_val_rn;
    assign o_val_rm        = r_val_rm;
    assign o_imm           = r_imm;
    assign o_shift_operand = r_shift_operand;
    assign o_signed_imm_24 = r_signed_imm_24;
    assign o_dest          = r_dest;
endmodule

// File: tb/tb_id_pipe_stage.sv
// Randomized self-checking bench for id_pipe_stage against a spec-level model (NREG=16 and NREG=8 copies).
module tb_id_pipe_stage;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid, exe_ready, flush, hazard, wb_we;
    logic [3:0]  sr, wb_dest;
    logic [8:0]  ctrl;
    logic [31:0] wb_data;

    logic        id_ready, two_src, out_valid, wb_en, mem_r_en, mem_w_en, b, s, imm;
    logic [3:0]  src1, src2, exe_cmd, dest;
    logic [31:0] val_rn, val_rm;
    logic [11:0] shift_op;
    logic [23:0] simm;

    logic        id_ready_8, two_src_8, out_valid_8, wb_en_8, mem_r_en_8, mem_w_en_8, b_8, s_8, imm_8;
    logic [3:0]  src1_8, src2_8, exe_cmd_8, dest_8;
    logic [31:0] val_rn_8, val_rm_8;
    logic [11:0] shift_op_8;
    logic [23:0] simm_8;

    id_pipe_stage #(.DATA_W(32), .NREG(16)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_instr_in(instr), .i_instr_valid(instr_valid),
        .o_id_ready(id_ready), .i_exe_ready(exe_ready), .i_flush(flush), .i_hazard(hazard),
        .i_sr(sr), .i_ctrl_in(ctrl), .i_wb_we(wb_we), .i_wb_dest(wb_dest), .i_wb_data(wb_data),
        .o_src1(src1), .o_src2(src2), .o_two_src(two_src), .o_out_valid(out_valid),
        .o_exe_cmd(exe_cmd), .o_wb_en(wb_en), .o_mem_r_en(mem_r_en), .o_mem_w_en(mem_w_en),
        .o_b(b), .o_s(s), .o_val_rn(val_rn), .o_val_rm(val_rm), .o_imm(imm),
        .o_shift_operand(shift_op), .o_signed_imm_24(simm), .o_dest(dest)
    );

    id_pipe_stage #(.DATA_W(32), .NREG(8)) u_dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_instr_in(instr), .i_instr_valid(instr_valid),
        .o_id_ready(id_ready_8), .i_exe_ready(exe_ready), .i_flush(flush), .i_hazard(hazard),
        .i_sr(sr), .i_ctrl_in(ctrl), .i_wb_we(wb_we), .i_wb_dest(wb_dest), .i_wb_data(wb_data),
        .o_src1(src1_8), .o_src2(src2_8), .o_two_src(two_src_8), .o_out_valid(out_valid_8),
        .o_exe_cmd(exe_cmd_8), .o_wb_en(wb_en_8), .o_mem_r_en(mem_r_en_8), .o_mem_w_en(mem_w_en_8),
        .o_b(b_8), .o_s(s_8), .o_val_rn(val_rn_8), .o_val_rm(val_rm_8), .o_imm(imm_8),
        .o_shift_operand(shift_op_8), .o_signed_imm_24(simm_8), .o_dest(dest_8)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_rf [16];
    logic [31:0] m8_rf [16];
    logic        m_valid, m_ctrl_known, m_imm;
    logic [8:0]  m_ctrl;
    logic [31:0] m_rn, m_rm, m8_rn, m8_rm;
    logic [11:0] m_shift;
    logic [23:0] m_simm;
    logic [3:0]  m_dest;

    // Condition codes come in predicate/negation pairs; 14 is always, 15 never.
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        if (c == 4'd14) return 1'b1;
        if (c == 4'd15) return 1'b0;
        case (int'(c) / 2)
            0: base = z;
            1: base = cf;
            2: base = n;
            3: base = v;
            4: base = cf && !z;
            5: base = (n == v);
            default: base = !z && (n == v);
        endcase
        return base ^ c[0];
    endfunction

    function automatic logic [31:0] mk(input logic [3:0] cond, input logic im, input logic [3:0] rn,
                                       input logic [3:0] rd, input logic [11:0] op);
        return {cond, 2'b00, im, 4'b0100, 1'b0, rn, rd, op};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_rf[i] = '0;
            m8_rf[i] = '0;
        end
        m_valid = 0; m_ctrl = '0; m_ctrl_known = 1; m_imm = 0;
        m_rn = '0; m_rm = '0; m8_rn = '0; m8_rm = '0;
        m_shift = '0; m_simm = '0; m_dest = '0;
    endtask

    task automatic model_edge();
        int rn, rm;
        logic [31:0] a, bv, a8, b8;
        rn = int'(instr[19:16]);
        rm = ctrl[2] ? int'(instr[15:12]) : int'(instr[3:0]);
        a  = m_rf[rn];
        bv = m_rf[rm];
        a8 = (rn < 8) ? m8_rf[rn] : 32'd0;
        b8 = (rm < 8) ? m8_rf[rm] : 32'd0;
`ifdef ID_WB_BYPASS_EN
        if (wb_we && int'(wb_dest) == rn) begin a = wb_data; if (rn < 8) a8 = wb_data; end
        if (wb_we && int'(wb_dest) == rm) begin bv = wb_data; if (rm < 8) b8 = wb_data; end
`endif
        if (flush) begin
            m_valid = 0;
            m_ctrl_known = 0;
        end else if (exe_ready || !m_valid) begin
            if (hazard || !instr_valid) begin
                m_valid = 0; m_ctrl = '0; m_ctrl_known = 1;
            end else begin
                m_valid = 1; m_ctrl_known = 1;
                m_ctrl = cond_ok(instr[31:28], sr) ? ctrl : 9'd0;
                m_rn = a; m_rm = bv; m8_rn = a8; m8_rm = b8;
                m_imm = instr[25]; m_shift = instr[11:0]; m_simm = instr[23:0]; m_dest = instr[15:12];
            end
        end
        if (wb_we) begin
            m_rf[wb_dest] = wb_data;
            if (wb_dest < 4'd8) m8_rf[wb_dest] = wb_data;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        instr_valid = 0; hazard = 0; flush = 0; wb_we = 0; exe_ready = 1;
        ctrl = '0; sr = '0; instr = '0; wb_dest = '0; wb_data = '0;
    endtask

    task automatic wb_write(input logic [3:0] d, input logic [31:0] v);
        instr_valid = 0; wb_we = 1; wb_dest = d; wb_data = v;
        tick();
        wb_we = 0;
    endtask

    task automatic test_reset();
        checks++;
        if (id_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_release: id_ready=%b out_valid=%b, want 1/0", id_ready, out_valid);
        end
        wb_write(4'd1, 32'd5);
        instr = mk(4'hE, 1'b0, 4'd1, 4'd2, 12'h003); ctrl = 9'h1F0; instr_valid = 1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || val_rn !== 32'd5) begin
            errors++; $display("FAIL reset_preload: out_valid=%b val_rn=%h, want 1/5", out_valid, val_rn);
        end
        exe_ready = 0;
        tick();
        #2 rst_n = 0;
        #1;
        checks++;
        if ({out_valid, exe_cmd, wb_en, mem_r_en, mem_w_en, b, s, val_rn, val_rm, imm, shift_op, simm, dest} !== '0) begin
            errors++; $display("FAIL reset_async: out_valid=%b val_rn=%h dest=%h exe_cmd=%h, want all 0",
                               out_valid, val_rn, dest, exe_cmd);
        end
        @(posedge clk); #1;
        rst_n = 1;
        model_reset();
        set_idle();
        checks++;
        if (id_ready !== 1'b1) begin
            errors++; $display("FAIL reset_id_ready: got %b want 1", id_ready);
        end
        instr = mk(4'hE, 1'b0, 4'd1, 4'd2, 12'h003); instr_valid = 1; ctrl = 9'h030;
        tick();
        checks++;
        if (out_valid !== 1'b1 || val_rn !== 32'd0) begin
            errors++; $display("FAIL reset_r1_cleared: out_valid=%b val_rn=%h, want 1/0", out_valid, val_rn);
        end
        set_idle();
        tick();
    endtask

    task automatic test_add();
        wb_write(4'd1, 32'd7);
        wb_write(4'd3, 32'd9);
        instr = mk(4'hE, 1'b0, 4'd1, 4'd2, 12'h003); ctrl = 9'h030; sr = 4'($urandom); instr_valid = 1;
        #1;
        checks++;
        if (src1 !== 4'd1 || src2 !== 4'd3 || two_src !== 1'b1) begin
            errors++; $display("FAIL add_srcs: src1=%0d src2=%0d two_src=%b, want 1/3/1", src1, src2, two_src);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || val_rn !== 32'd7 || val_rm !== 32'd9 || dest !== 4'd2) begin
            errors++; $display("FAIL add_bundle: v=%b rn=%0d rm=%0d dest=%0d, want 1/7/9/2", out_valid, val_rn, val_rm, dest);
        end
        checks++;
        if ({exe_cmd, wb_en, mem_r_en, mem_w_en, b, s} !== 9'h030) begin
            errors++; $display("FAIL add_ctrl: got %h want 030", {exe_cmd, wb_en, mem_r_en, mem_w_en, b, s});
        end
        set_idle();
    endtask

    task automatic test_cond();
        instr = mk(4'h0, 1'b1, 4'd5, 4'd6, 12'hABC); ctrl = 9'h1FF; sr = 4'b0000; instr_valid = 1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || {exe_cmd, wb_en, mem_r_en, mem_w_en, b, s} !== 9'h000 || dest !== 4'd6
            || shift_op !== 12'hABC || imm !== 1'b1) begin
            errors++; $display("FAIL cond_eq_fail: v=%b ctrl=%h dest=%0d shift=%h imm=%b, want 1/000/6/abc/1",
                               out_valid, {exe_cmd, wb_en, mem_r_en, mem_w_en, b, s}, dest, shift_op, imm);
        end
        instr = mk(4'h1, 1'b0, 4'd5, 4'd6, 12'h001);
        tick();
        checks++;
        if ({exe_cmd, wb_en, mem_r_en, mem_w_en, b, s} !== 9'h1FF) begin
            errors++; $display("FAIL cond_ne_pass: ctrl=%h want 1ff", {exe_cmd, wb_en, mem_r_en, mem_w_en, b, s});
        end
        instr = mk(4'hF, 1'b0, 4'd5, 4'd6, 12'h001); sr = 4'hF;
        tick();
        checks++;
        if (out_valid !== 1'b1 || {exe_cmd, wb_en, mem_r_en, mem_w_en, b, s} !== 9'h000) begin
            errors++; $display("FAIL cond_never: v=%b ctrl=%h want 1/000", out_valid, {exe_cmd, wb_en, mem_r_en, mem_w_en, b, s});
        end
        set_idle();
    endtask

    task automatic test_backpressure();
        instr = mk(4'hE, 1'b0, 4'd2, 4'd3, 12'h004); ctrl = 9'h048; instr_valid = 1;
        tick();
        exe_ready = 0;
        instr = mk(4'hE, 1'b0, 4'd5, 4'd7, 12'h001); ctrl = 9'h0A0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (id_ready !== 1'b0) begin
                errors++; $display("FAIL stall_id_ready[%0d]: got %b want 0", i, id_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || dest !== 4'd3 || {exe_cmd, wb_en, mem_r_en, mem_w_en, b, s} !== 9'h048
                || val_rn !== m_rn || val_rm !== m_rm) begin
                errors++; $display("FAIL stall_hold[%0d]: v=%b dest=%0d ctrl=%h rn=%h rm=%h, want 1/3/048/%h/%h",
                                   i, out_valid, dest, {exe_cmd, wb_en, mem_r_en, mem_w_en, b, s}, val_rn, val_rm, m_rn, m_rm);
            end
        end
        exe_ready = 1;
        #1;
        checks++;
        if (id_ready !== 1'b1) begin
            errors++; $display("FAIL stall_release_ready: got %b want 1", id_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || dest !== 4'd7 || {exe_cmd, wb_en, mem_r_en, mem_w_en, b, s} !== 9'h0A0) begin
            errors++; $display("FAIL stall_next_load: v=%b dest=%0d ctrl=%h, want 1/7/0a0",
                               out_valid, dest, {exe_cmd, wb_en, mem_r_en, mem_w_en, b, s});
        end
        set_idle();
    endtask

    task automatic test_hazard_flush();
        instr = mk(4'hE, 1'b0, 4'd1, 4'd2, 12'h003); ctrl = 9'h1F0; instr_valid = 1; hazard = 1;
        #1;
        checks++;
        if (id_ready !== 1'b0) begin
            errors++; $display("FAIL hazard_id_ready: got %b want 0", id_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || {exe_cmd, wb_en, mem_r_en, mem_w_en, b, s} !== 9'h000) begin
            errors++; $display("FAIL hazard_bubble: v=%b ctrl=%h want 0/000", out_valid, {exe_cmd, wb_en, mem_r_en, mem_w_en, b, s});
        end
        hazard = 0; flush = 1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_accept: out_valid=%b want 0", out_valid);
        end
        flush = 0;
        tick();
        exe_ready = 0; flush = 1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_held: out_valid=%b want 0", out_valid);
        end
        set_idle();
    endtask

    task automatic test_bypass();
        logic [31:0] exp_rm;
`ifdef ID_WB_BYPASS_EN
        exp_rm = 32'hAA;
`else
        exp_rm = 32'h11;
`endif
        wb_write(4'd4, 32'h11);
        wb_write(4'd12, 32'h55);
        instr = mk(4'hE, 1'b0, 4'd12, 4'd0, 12'h004); ctrl = 9'h030; instr_valid = 1;
        wb_we = 1; wb_dest = 4'd4; wb_data = 32'hAA;
        tick();
        checks++;
        if (val_rm !== exp_rm || val_rn !== 32'h55) begin
            errors++; $display("FAIL bypass16: rm=%h rn=%h want %h/55", val_rm, val_rn, exp_rm);
        end
        checks++;
        if (val_rm_8 !== exp_rm || val_rn_8 !== 32'h0) begin
            errors++; $display("FAIL bypass8_r12_dropped: rm=%h rn=%h want %h/0", val_rm_8, val_rn_8, exp_rm);
        end
        wb_we = 0;
        tick();
        checks++;
        if (val_rm !== 32'hAA || val_rm_8 !== 32'hAA) begin
            errors++; $display("FAIL bypass_after_write: rm=%h rm8=%h want aa/aa", val_rm, val_rm_8);
        end
        set_idle();
    endtask

    task automatic test_random();
        logic [3:0] exp_src2;
        for (int i = 0; i < 400; i++) begin
            instr       = $urandom;
            if ($urandom_range(0, 3) != 0) instr[31:28] = 4'hE;
            ctrl        = 9'($urandom);
            sr          = 4'($urandom);
            instr_valid = ($urandom_range(0, 9) < 8);
            exe_ready   = ($urandom_range(0, 9) < 7);
            hazard      = ($urandom_range(0, 9) == 0);
            flush       = ($urandom_range(0, 19) == 0);
            wb_we       = ($urandom_range(0, 1) == 1);
            wb_dest     = 4'($urandom);
            wb_data     = $urandom;
            #1;
            exp_src2 = ctrl[2] ? instr[15:12] : instr[3:0];
            checks++;
            if (id_ready !== ((exe_ready || !m_valid) && !hazard) || src1 !== instr[19:16] || src2 !== exp_src2
                || two_src !== (!instr[25] || ctrl[2])) begin
                errors++; $display("FAIL rnd_comb[%0d]: id_ready=%b src1=%h src2=%h two_src=%b, want %b/%h/%h/%b",
                                   i, id_ready, src1, src2, two_src, (exe_ready || !m_valid) && !hazard,
                                   instr[19:16], exp_src2, !instr[25] || ctrl[2]);
            end
            tick();
            checks++;
            if (out_valid !== m_valid || out_valid_8 !== m_valid) begin
                errors++; $display("FAIL rnd_valid[%0d]: got %b/%b want %b", i, out_valid, out_valid_8, m_valid);
            end
            if (m_ctrl_known) begin
                checks++;
                if ({exe_cmd, wb_en, mem_r_en, mem_w_en, b, s} !== m_ctrl) begin
                    errors++; $display("FAIL rnd_ctrl[%0d]: got %h want %h", i, {exe_cmd, wb_en, mem_r_en, mem_w_en, b, s}, m_ctrl);
                end
            end
            if (m_valid) begin
                checks++;
                if ({val_rn, val_rm, imm, shift_op, simm, dest} !== {m_rn, m_rm, m_imm, m_shift, m_simm, m_dest}) begin
                    errors++; $display("FAIL rnd_bundle[%0d]: rn=%h rm=%h imm=%b sh=%h si=%h d=%h want %h %h %b %h %h %h",
                                       i, val_rn, val_rm, imm, shift_op, simm, dest, m_rn, m_rm, m_imm, m_shift, m_simm, m_dest);
                end
                checks++;
                if (val_rn_8 !== m8_rn || val_rm_8 !== m8_rm) begin
                    errors++; $display("FAIL rnd_ops8[%0d]: rn=%h rm=%h want %h %h", i, val_rn_8, val_rm_8, m8_rn, m8_rm);
                end
            end
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        test_reset();
        test_add();
        test_cond();
        test_backpressure();
        test_hazard_flush();
        test_bypass();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_pipe_stage.md
# id_pipe_stage

Parametrised decode stage with an integrated register file and a registered ID/EXE output with a valid/ready handshake. It sits between the IF/ID register and the execute stage. It extracts ARM instruction fields, evaluates the condition code against the status flags, and reads two operands with an optional same-cycle write-back bypass. It then presents a registered, stallable and flushable bundle to EXE, so no separate ID/EXE register is needed.

## Interface
- DATA_W, 32, operand and register width
- NREG, 16, implemented registers (1..16); indices ≥ NREG read 0, writes to them are dropped
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- instr_in  in  32  instruction from IF/ID register
- instr_valid  in  1  instr_in is valid
- id_ready  out  1  stage accepts instr_in this cycle
- exe_ready  in  1  EXE accepts the output bundle this cycle
- flush  in  1  discard the held and incoming instruction (branch taken)
- hazard  in  1  from hazard unit: do not accept, insert bubble
- sr  in  4  status flags {N,Z,C,V}
- ctrl_in  in  9  control unit output {exe_cmd[3:0], wb_en, mem_r_en, mem_w_en, b, s}
- wb_we, wb_dest, wb_data  in  1/4/DATA_W  write-back port
- src1, src2  out  4  combinational Rn and Rm-select, to hazard unit
- two_src  out  1  combinational, ~instr_in[25] | ctrl_in mem_w_en
- out_valid  out  1  registered, bundle valid
- exe_cmd, wb_en, mem_r_en, mem_w_en, b, s  out  4/1/1/1/1/1  registered control
- val_rn, val_rm  out  DATA_W  registered operands
- imm, shift_operand, signed_imm_24, dest  out  1/12/24/4  registered fields

## Operation
- Fields: cond=[31:28], imm=[25], Rn=[19:16], Rd=[15:12], shift_operand=[11:0], signed_imm_24=[23:0].
- Rm-select: src2 = Rd when ctrl_in mem_w_en, else instr_in[3:0].
- Condition codes: EQ Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V; HI C&~Z; LS ~C|Z; GE N==V; LT N!=V; GT ~Z&(N==V); LE Z|(N!=V); AL 1; 1111 never.
- id_ready = (exe_ready | ~out_valid) & ~hazard.
- Output register loads when exe_ready | ~out_valid. Priority: flush > hazard > accept.
  - flush: out_valid←0.
  - hazard, or no instr_valid: out_valid←0 (bubble); other fields don't-care but control bits forced 0.
  - accept: out_valid←1, fields captured. If the condition fails, all 9 control bits ←0 and operands/fields are still captured.
- While out_valid & ~exe_ready and no flush, all outputs hold.
- Register file: NREG×DATA_W. Written at the rising edge when wb_we & wb_dest<NREG. Reads are combinational on Rn and src2.
- Reset: all registers 0, out_valid 0, all registered outputs 0.

## Timing
- Latency: 1 cycle, from accept edge to out_valid.
- Throughput: 1 per cycle while exe_ready=1.
- Back-pressure: a held bundle is stable until the edge where exe_ready=1.
- Flush and accept in the same cycle: the instruction is dropped and out_valid=0 next cycle.
- Write and read of the same register in the same cycle: see Configuration.
- Reset asserted mid-stall clears out_valid immediately (asynchronous).
- Reset release: id_ready=1 on the first cycle, provided hazard=0.

## Configuration
- ID_WB_BYPASS_EN defined: when wb_we & wb_dest==read index (<NREG), the read returns wb_data in the same cycle.
- ID_WB_BYPASS_EN undefined: the read returns the pre-write value; the hazard unit must stall one extra cycle.

## Test plan
- Reset: write R1=5 then assert rst=0 mid-stream -> out_valid=0 and all outputs 0 at once; after release, R1 reads 0.
- ADD R2,R1,R3 (cond AL), R1=7, R3=9, exe_ready=1 -> next cycle out_valid=1, val_rn=7, val_rm=9, dest=2, exe_cmd=ctrl_in value.
- EQ-conditioned instruction with sr=0000 -> out_valid=1, all control bits 0, dest still captured.
- exe_ready=0 for 3 cycles with a bundle held -> outputs unchanged and id_ready=0; exe_ready=1 -> next instruction loads the following cycle.
- hazard=1 for one cycle, then flush=1 with instr_valid=1 -> bubble (out_valid=0) in both cycles, id_ready=0 during the hazard cycle.
- wb_we=1, wb_dest=4, wb_data=0xAA while reading R4 (old value 0x11) -> val_rm=0xAA with ID_WB_BYPASS_EN, 0x11 without. With NREG=8, a write to R12 is dropped and a read of R12 returns 0.
